// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver.
// Runs on the system clock and samples each serial bit at its mid-point.
// Received words are delivered over a valid/ready handshake. The parity
// and stop-bit status travels with each word. A finished frame that cannot
// be stored because the output is still full produces an overrun pulse.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,  // system clocks per serial bit (>=4, even)
    parameter int DATA_BITS    = 8,   // payload bits per frame, 5..9, LSB first
    parameter int PARITY_EN    = 0,   // 1 = one parity bit follows the data
    parameter int PARITY_ODD   = 0,   // 1 = odd parity, 0 = even
    parameter int STOP_BITS    = 1    // stop bits checked, 1 or 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [2:0]           state_out
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);
    localparam logic          HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_WAIT_HI = 3'd5
    } state_t;

    logic [1:0]           sync_q;
    logic                 rx_s;

    state_t               state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [BW-1:0]        bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 perr, perr_next;
    logic                 ferr, ferr_next;
    logic                 complete;

    // Two-flop synchroniser for the asynchronous serial line. The flops reset
    // to the idle level so that reset release cannot look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of the others.
            sync_q <= {sync_q[0], rx_in};
        end
    end

    assign rx_s = sync_q[1];

    // Frame state register and the bit-timing and shift datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            perr    <= perr_next;
            ferr    <= ferr_next;
        end
    end

    // Next-state logic: the bit timer, the sample points and frame completion.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves a signal unassigned and infers a latch.
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        perr_next    = perr;
        ferr_next    = ferr;
        complete     = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next = S_START;
                    cnt_next   = '0;
                end
            end

            S_START: begin
                // Check the start bit again half a bit later. A high line here
                // was only a glitch.
                if (cnt == CNT_HALF) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next   = S_DATA;
                        bit_idx_next = '0;
                        perr_next    = 1'b0;
                        ferr_next    = 1'b0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end

            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    // Shifting in from the MSB puts the first bit, which is
                    // the LSB, at bit 0 once all DATA_BITS bits have arrived.
                    shift_next = {rx_s, shift[DATA_BITS-1:1]};
                    if (bit_idx == BIT_LAST) begin
                        bit_idx_next = '0;
                        state_next   = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_next = bit_idx + BW'(1);
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end

            S_PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    perr_next  = ((^shift) ^ rx_s) != PAR_ODD;
                    state_next = S_STOP;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end

            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_next  = '0;
                    ferr_next = ferr | ~rx_s;
                    if (bit_idx == STOP_LAST) begin
                        complete     = 1'b1;
                        bit_idx_next = '0;
                        // A line still low after the frame is a break or a
                        // stuck line. Wait for it to go high before looking
                        // for the next start bit.
                        state_next   = rx_s ? S_IDLE : S_WAIT_HI;
                    end else begin
                        bit_idx_next = bit_idx + BW'(1);
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end

            S_WAIT_HI: begin
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output holding register: load on completion when the output is free,
    // clear on acceptance, and drop the frame with an overrun pulse otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shift_next;
                    parity_err <= perr_next;
                    frame_err  <= ferr_next;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench for uart_rx_param.
// Instance "a" uses the default 8N1 configuration. Instance "b" has even
// parity enabled.
module tb_uart_rx_param;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       rx_a = 1'b1;
    logic       ready_a = 1'b1;
    logic [7:0] data_a;
    logic       valid_a, pe_a, fe_a, ov_sig_a;
    logic [2:0] st_a;

    logic       rx_b = 1'b1;
    logic       ready_b = 1'b1;
    logic [7:0] data_b;
    logic       valid_b, pe_b, fe_b, ov_sig_b;
    logic [2:0] st_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0),
                    .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_a), .rx_data(data_a),
        .rx_valid(valid_a), .rx_ready(ready_a), .parity_err(pe_a),
        .frame_err(fe_a), .overrun(ov_sig_a), .state_out(st_a)
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1),
                    .PARITY_ODD(0), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_b), .rx_data(data_b),
        .rx_valid(valid_b), .rx_ready(ready_b), .parity_err(pe_b),
        .frame_err(fe_b), .overrun(ov_sig_b), .state_out(st_b)
    );

    // Delivery monitors: count each newly loaded word, record its contents,
    // and count the cycles in which overrun is high.
    int         n_a = 0, ov_a = 0, n_b = 0;
    logic [7:0] last_a = '0, last_b = '0;
    logic       last_pe_a = 1'b0, last_fe_a = 1'b0;
    logic       last_pe_b = 1'b0, last_fe_b = 1'b0;
    logic       free_a = 1'b1, free_b = 1'b1;

    always @(negedge clk) begin
        if (valid_a && free_a) begin
            n_a       <= n_a + 1;
            last_a    <= data_a;
            last_pe_a <= pe_a;
            last_fe_a <= fe_a;
        end
        free_a <= !valid_a || ready_a;
        if (ov_sig_a) ov_a <= ov_a + 1;
    end

    always @(negedge clk) begin
        if (valid_b && free_b) begin
            n_b       <= n_b + 1;
            last_b    <= data_b;
            last_pe_b <= pe_b;
            last_fe_b <= fe_b;
        end
        free_b <= !valid_b || ready_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input bit which, input logic v);
        if (which) rx_b = v;
        else       rx_a = v;
        wait_clks(CPB);
    endtask

    // Send one frame: start bit, 8 data bits LSB first, an optional parity
    // bit, one stop bit. The line keeps the stop-bit level afterwards.
    task automatic send_frame(input bit which, input logic [7:0] d,
                              input bit use_par, input logic par_bit,
                              input logic stop_bit);
        wait_clks(1);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (use_par) drive_bit(which, par_bit);
        drive_bit(which, stop_bit);
    endtask

    int n0, ov0;

    initial begin
        // Reset state
        wait_clks(3);
        check("rst_data",    32'(data_a),   32'h0);
        check("rst_valid",   32'(valid_a),  32'h0);
        check("rst_perr",    32'(pe_a),     32'h0);
        check("rst_ferr",    32'(fe_a),     32'h0);
        check("rst_overrun", 32'(ov_sig_a), 32'h0);
        check("rst_state",   32'(st_a),     32'h0);
        check("rst_valid_b", 32'(valid_b),  32'h0);
        check("rst_ov_b",    32'(ov_sig_b), 32'h0);
        check("rst_state_b", 32'(st_b),     32'h0);
        rst_n = 1'b1;
        wait_clks(4);

        // T1: 0xA5, 8N1, consumer always ready
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_clks(2 * CPB);
        check("t1_count", 32'(n_a),       32'd1);
        check("t1_data",  32'(last_a),    32'hA5);
        check("t1_perr",  32'(last_pe_a), 32'h0);
        check("t1_ferr",  32'(last_fe_a), 32'h0);
        check("t1_valid", 32'(valid_a),   32'h0);
        check("t1_state", 32'(st_a),      32'h0);

        // T2: line low for 4 clocks only, which is a glitch
        rx_a = 1'b0;
        wait_clks(4);
        check("t2_in_start", 32'(st_a), 32'h1);
        rx_a = 1'b1;
        wait_clks(20);
        check("t2_idle",  32'(st_a), 32'h0);
        check("t2_count", 32'(n_a),  32'd1);

        // T3: even parity on 0x3C, which has four ones. Parity bit 1 is wrong.
        send_frame(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
        wait_clks(2 * CPB);
        check("t3a_count", 32'(n_b),       32'd1);
        check("t3a_data",  32'(last_b),    32'h3C);
        check("t3a_perr",  32'(last_pe_b), 32'h1);
        check("t3a_ferr",  32'(last_fe_b), 32'h0);
        send_frame(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
        wait_clks(2 * CPB);
        check("t3b_count", 32'(n_b),       32'd2);
        check("t3b_data",  32'(last_b),    32'h3C);
        check("t3b_perr",  32'(last_pe_b), 32'h0);

        // T4: 0x55 with a low stop bit, then the line stays low for 40 clocks
        n0 = n_a;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        wait_clks(40);
        check("t4_count", 32'(n_a),       32'(n0 + 1));
        check("t4_data",  32'(last_a),    32'h55);
        check("t4_ferr",  32'(last_fe_a), 32'h1);
        check("t4_perr",  32'(last_pe_a), 32'h0);
        check("t4_wait",  32'(st_a),      32'h5);
        rx_a = 1'b1;
        wait_clks(5);
        check("t4_idle", 32'(st_a), 32'h0);
        wait_clks(2 * CPB);
        check("t4_no_new", 32'(n_a), 32'(n0 + 1));

        // T5: consumer stalled, so the second frame is dropped with an overrun
        ready_a = 1'b0;
        n0  = n_a;
        ov0 = ov_a;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        wait_clks(CPB);
        check("t5_valid1", 32'(valid_a), 32'h1);
        check("t5_data1",  32'(data_a),  32'h11);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        wait_clks(CPB);
        check("t5_hold_data",  32'(data_a),  32'h11);
        check("t5_hold_valid", 32'(valid_a), 32'h1);
        check("t5_overrun",    32'(ov_a),    32'(ov0 + 1));
        check("t5_count",      32'(n_a),     32'(n0 + 1));
        ready_a = 1'b1;
        wait_clks(2);
        check("t5_accepted", 32'(valid_a), 32'h0);
        check("t5_ferr_clr", 32'(fe_a),    32'h0);
        check("t5_count2",   32'(n_a),     32'(n0 + 1));

        // T6: reset in the middle of the data bits of 0x7E, then send 0x81
        rx_a = 1'b0;
        wait_clks(CPB);
        rx_a = 1'b0;
        wait_clks(CPB);
        rx_a = 1'b1;
        wait_clks(CPB);
        rx_a = 1'b1;
        wait_clks(CPB / 2);
        check("t6_in_data", 32'(st_a), 32'h2);
        rst_n = 1'b0;
        wait_clks(1);
        check("t6_rst_data",  32'(data_a),   32'h0);
        check("t6_rst_valid", 32'(valid_a),  32'h0);
        check("t6_rst_perr",  32'(pe_a),     32'h0);
        check("t6_rst_ferr",  32'(fe_a),     32'h0);
        check("t6_rst_ov",    32'(ov_sig_a), 32'h0);
        check("t6_rst_state", 32'(st_a),     32'h0);
        rx_a = 1'b1;
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(4);
        n0 = n_a;
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        wait_clks(2 * CPB);
        check("t6_count", 32'(n_a),       32'(n0 + 1));
        check("t6_data",  32'(last_a),    32'h81);
        check("t6_ferr",  32'(last_fe_a), 32'h0);
        check("t6_state", 32'(st_a),      32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
